// File: rtl/divider_iter.sv
// Iterative radix-2 restoring divider, signed/unsigned, one operation at a time.
// Optional leading-zero early-out when DIVIDER_EARLY_OUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for en; operands latched on accept
// PREP  | absolute values, result signs, iteration count, divide-by-zero bypass
// ITER  | one restoring step per cycle
// DONE  | sign-corrected results registered, ready pulse
module divider_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             en,
  input  logic             sign,
  input  logic             flush_exception,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             stall_divider,
  output logic             ready
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvd_r, dvs_r, dvs_abs, rem_r, q_r;
  logic             sign_r, q_neg, r_neg;
  logic [CW-1:0]    cnt;

  logic             dvd_neg, dvs_neg, dvs_zero;
  logic [WIDTH-1:0] dvd_abs, dvs_abs_nxt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  assign dvd_neg     = sign_r & dvd_r[WIDTH-1];
  assign dvs_neg     = sign_r & dvs_r[WIDTH-1];
  assign dvs_zero    = (dvs_r == '0);
  assign dvd_abs     = dvd_neg ? (WIDTH'(0) - dvd_r) : dvd_r;
  assign dvs_abs_nxt = dvs_neg ? (WIDTH'(0) - dvs_r) : dvs_r;

  // Partial remainder stays below the divisor, so the low WIDTH bits of the
  // difference are exact whenever the subtraction is taken.
  assign shifted = {rem_r, q_r[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, dvs_abs});
  assign diff    = shifted[WIDTH-1:0] - dvs_abs;

`ifdef DIVIDER_EARLY_OUT_EN
  logic [CW-1:0] clz;

  always_comb begin
    clz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (dvd_abs[i]) clz = CW'(WIDTH - 1 - i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush_exception) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (en) state_nxt = PREP;
        PREP: begin
          if (dvs_zero) state_nxt = DONE;
`ifdef DIVIDER_EARLY_OUT_EN
          else if (clz == CW'(WIDTH)) state_nxt = DONE;
`endif
          else state_nxt = ITER;
        end
        ITER: if (cnt == CW'(1)) state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    stall_divider = ((state == IDLE) & en & ~flush_exception) |
                    (state == PREP) | (state == ITER);
    ready         = (state == DONE) & ~flush_exception;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dvd_r     <= '0;
      dvs_r     <= '0;
      sign_r    <= 1'b0;
      dvs_abs   <= '0;
      rem_r     <= '0;
      q_r       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && !flush_exception) begin
            dvd_r  <= dividend;
            dvs_r  <= divisor;
            sign_r <= sign;
          end
        end
        PREP: begin
          dvs_abs <= dvs_abs_nxt;
          if (dvs_zero) begin
            // Divide-by-zero: all-ones quotient, raw dividend, no sign fix-up.
            q_r   <= '1;
            rem_r <= dvd_r;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            cnt   <= '0;
          end else begin
            rem_r <= '0;
            q_neg <= sign_r & (dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1]);
            r_neg <= dvd_neg;
`ifdef DIVIDER_EARLY_OUT_EN
            q_r   <= dvd_abs << clz;
            cnt   <= CW'(WIDTH) - clz;
`else
            q_r   <= dvd_abs;
            cnt   <= CW'(WIDTH);
`endif
          end
        end
        ITER: begin
          rem_r <= ge ? diff : shifted[WIDTH-1:0];
          q_r   <= {q_r[WIDTH-2:0], ge};
          cnt   <= cnt - CW'(1);
        end
        DONE: begin
          if (!flush_exception) begin
            quotient  <= q_neg ? (WIDTH'(0) - q_r)   : q_r;
            remainder <= r_neg ? (WIDTH'(0) - rem_r) : rem_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
